// File: rtl/alu_issue_stage_pkg.sv
// Shared constants and ALUOp encodings for the ALU issue stage, the ALU and their benches.
package alu_issue_stage_pkg;

    localparam int unsigned DataW = 32;
    localparam int unsigned RegN  = 32;
    localparam int unsigned AddrW = 5;
    localparam int unsigned OpW   = 3;
    localparam int unsigned CntW  = 32;

    // Codes 110/111 are unassigned; the issue stage forwards them untouched.
    typedef enum logic [OpW-1:0] {
        AluAdd = 3'b000,
        AluSub = 3'b001,
        AluAnd = 3'b010,
        AluOr  = 3'b011,
        AluXor = 3'b100,
        AluSlt = 3'b101
    } alu_op_e;

endpackage

// File: rtl/grf_2r1w.sv
// General register file: two async read ports plus a debug read, one sync write port,
// async active-low clear, register 0 hardwired to zero.
module grf_2r1w
    import alu_issue_stage_pkg::*;
#(
    parameter int unsigned DATA_W = DataW,
    parameter int unsigned REG_N  = RegN,
    parameter int unsigned ADDR_W = AddrW
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] ra_addr_i,
    output logic [DATA_W-1:0] ra_data_o,
    input  logic [ADDR_W-1:0] rb_addr_i,
    output logic [DATA_W-1:0] rb_data_o,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o
);

    logic [DATA_W-1:0] mem_q [REG_N];

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        return (addr == '0) ? '0 : mem_q[addr];
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(REG_N); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            // Entry 0 is never written, so it stays at its cleared value.
            for (int i = 1; i < int'(REG_N); i++) begin
                if (we_i && (waddr_i == ADDR_W'(i))) begin
                    mem_q[i] <= wdata_i;
                end
            end
        end
    end

    always_comb begin
        ra_data_o  = read_port(ra_addr_i);
        rb_data_o  = read_port(rb_addr_i);
        dbg_data_o = read_port(dbg_addr_i);
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Operand-issue stage ahead of the ALU: reads rs/rt from the GRF (with writeback bypass),
// holds A/B/ALUOp for the ALU and writes the result back to rd on retirement.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int unsigned DATA_W = DataW,
    parameter int unsigned REG_N  = RegN,
    parameter int unsigned ADDR_W = AddrW,
    parameter int unsigned OP_W   = OpW
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_rs,
    input  logic [ADDR_W-1:0] in_rt,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [OP_W-1:0]   in_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_c,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CntW-1:0]   retire_cnt,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [OP_W-1:0]   alu_op_q, alu_op_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic              out_valid_q, out_valid_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic              accept;
    logic              retire;
    logic              wb_en;
    logic [DATA_W-1:0] grf_a, grf_b;
    logic [DATA_W-1:0] opnd_a, opnd_b;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign retire   = out_valid_q && out_ready;
    assign wb_en    = retire && (rd_q != '0);

    grf_2r1w #(
        .DATA_W (DATA_W),
        .REG_N  (REG_N),
        .ADDR_W (ADDR_W)
    ) u_grf (
        .clk        (clk),
        .reset_n    (reset_n),
        .we_i       (wb_en),
        .waddr_i    (rd_q),
        .wdata_i    (alu_c),
        .ra_addr_i  (in_rs),
        .ra_data_o  (grf_a),
        .rb_addr_i  (in_rt),
        .rb_data_o  (grf_b),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data)
    );

    // A result retiring this cycle is not in the GRF yet, so forward it to a matching reader.
    always_comb begin
        opnd_a = grf_a;
        opnd_b = grf_b;
        if (wb_en && (rd_q == in_rs)) begin
            opnd_a = alu_c;
        end
        if (wb_en && (rd_q == in_rt)) begin
            opnd_b = alu_c;
        end
    end

    always_comb begin
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        rd_d        = rd_q;
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q;
        if (accept) begin
            alu_a_d     = opnd_a;
            alu_b_d     = opnd_b;
            alu_op_d    = in_op;
            rd_d        = in_rd;
            out_valid_d = 1'b1;
        end else if (retire) begin
            out_valid_d = 1'b0;
        end
        if (retire) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            rd_q        <= '0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            rd_q        <= rd_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign out_valid  = out_valid_q;
    assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a small behavioural ALU closing the loop on alu_c.
module tb_alu_issue_stage;
    import alu_issue_stage_pkg::*;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [AddrW-1:0] in_rs, in_rt, in_rd;
    logic [OpW-1:0]   in_op;
    logic [DataW-1:0] alu_a, alu_b, alu_c;
    logic [OpW-1:0]   alu_op;
    logic             out_valid;
    logic             out_ready;
    logic [CntW-1:0]  retire_cnt;
    logic [AddrW-1:0] dbg_addr;
    logic [DataW-1:0] dbg_data;

    logic             c_ovr;
    logic [DataW-1:0] c_val;

    int checks = 0;
    int errors = 0;

    logic [OpW-1:0]  stream_ops [3] = '{3'b000, 3'b011, 3'b101};
    logic [CntW-1:0] stream_cnt [3] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000};

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_rd      (in_rd),
        .in_op      (in_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_c      (alu_c),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .retire_cnt (retire_cnt),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    always_comb begin
        alu_c = '0;
        if (c_ovr) begin
            alu_c = c_val;
        end else begin
            case (alu_op)
                AluAdd:  alu_c = alu_a + alu_b;
                AluSub:  alu_c = alu_a - alu_b;
                AluAnd:  alu_c = alu_a & alu_b;
                AluOr:   alu_c = alu_a | alu_b;
                AluXor:  alu_c = alu_a ^ alu_b;
                AluSlt:  alu_c = {31'd0, $signed(alu_a) < $signed(alu_b)};
                default: alu_c = '0;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input string tag, input logic [AddrW-1:0] addr, input logic [31:0] exp);
        dbg_addr = addr;
        #1;
        check(tag, dbg_data, exp);
    endtask

    // Loads a register through a full accept/retire pass with a forced ALU result.
    task automatic write_reg(input logic [AddrW-1:0] rd, input logic [31:0] val);
        in_valid  = 1'b1;
        in_rs     = '0;
        in_rt     = '0;
        in_rd     = rd;
        in_op     = '0;
        out_ready = 1'b1;
        c_ovr     = 1'b1;
        c_val     = val;
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_rs     = '0;
        in_rt     = '0;
        in_rd     = '0;
        in_op     = '0;
        out_ready = 1'b1;
        c_ovr     = 1'b0;
        c_val     = '0;
        dbg_addr  = '0;
        #12;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_cnt", retire_cnt, 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_op", {29'd0, alu_op}, 32'd0);
        tick();
        reset_n = 1'b1;

        // Writeback through the model ALU: 32 + 16 -> r3.
        write_reg(5'd1, 32'd32);
        write_reg(5'd2, 32'd16);
        peek("wb_r1", 5'd1, 32'd32);
        peek("wb_r2", 5'd2, 32'd16);
        in_valid = 1'b1; in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd3; in_op = 3'b000; c_ovr = 1'b0;
        tick();
        in_valid = 1'b0;
        check("wb_alu_a", alu_a, 32'd32);
        check("wb_alu_b", alu_b, 32'd16);
        check("wb_out_valid", {31'd0, out_valid}, 32'd1);
        peek("wb_r3_before", 5'd3, 32'd0);
        tick();
        peek("wb_r3", 5'd3, 32'd48);
        check("wb_cnt", retire_cnt, 32'd3);
        check("wb_drain", {31'd0, out_valid}, 32'd0);

        // Bypass: r3 retires 0x30 on the same edge that an op reading r3 twice is accepted.
        write_reg(5'd3, 32'h11);
        peek("byp_r3_stale", 5'd3, 32'h11);
        in_valid = 1'b1; in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd3; in_op = 3'b000;
        c_val = 32'h30;
        tick();
        in_rs = 5'd3; in_rt = 5'd3; in_rd = 5'd4; in_op = 3'b001;
        #1;
        check("byp_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("byp_alu_a", alu_a, 32'h30);
        check("byp_alu_b", alu_b, 32'h30);
        check("byp_alu_op", {29'd0, alu_op}, 32'd1);
        peek("byp_r3", 5'd3, 32'h30);
        c_val = 32'h55;
        tick();
        peek("byp_r4", 5'd4, 32'h55);
        check("byp_cnt", retire_cnt, 32'd6);

        // Backpressure: held op must not move or write back while out_ready is low.
        in_valid = 1'b1; in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd5; in_op = 3'b010;
        c_val = 32'hA5A5;
        tick();
        in_rs = 5'd4; in_rd = 5'd6; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            tick();
            check("bp_alu_a", alu_a, 32'd32);
            check("bp_alu_b", alu_b, 32'd16);
            check("bp_alu_op", {29'd0, alu_op}, 32'd2);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_cnt", retire_cnt, 32'd6);
            peek("bp_r5_nowrite", 5'd5, 32'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        peek("bp_r5", 5'd5, 32'hA5A5);
        peek("bp_r6", 5'd6, 32'd0);
        check("bp_cnt_inc", retire_cnt, 32'd7);
        check("bp_drain", {31'd0, out_valid}, 32'd0);

        // Register 0 drops writes but the retirement still counts.
        write_reg(5'd0, 32'hDEAD_BEEF);
        peek("r0_read", 5'd0, 32'd0);
        check("r0_cnt", retire_cnt, 32'd8);

        // Unassigned ALUOp codes pass straight through.
        in_valid = 1'b1; in_rd = 5'd0; in_op = 3'b110;
        tick();
        check("op110", {29'd0, alu_op}, 32'd6);
        in_op = 3'b111;
        tick();
        check("op111", {29'd0, alu_op}, 32'd7);
        in_valid = 1'b0;
        tick();
        check("op_cnt", retire_cnt, 32'd10);

        // Reset while an op is held: it must be discarded without writeback.
        in_valid = 1'b1; in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd7; in_op = 3'b011;
        c_val = 32'h77;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        tick();
        check("mr_held", {31'd0, out_valid}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("mr_out_valid", {31'd0, out_valid}, 32'd0);
        check("mr_cnt", retire_cnt, 32'd0);
        check("mr_alu_a", alu_a, 32'd0);
        check("mr_alu_b", alu_b, 32'd0);
        check("mr_alu_op", {29'd0, alu_op}, 32'd0);
        for (int i = 0; i < 32; i++) begin
            peek("mr_grf", AddrW'(i), 32'd0);
        end
        tick();
        reset_n = 1'b1; out_ready = 1'b1;
        tick();
        peek("mr_r7", 5'd7, 32'd0);
        check("mr_cnt_after", retire_cnt, 32'd0);

        // Stream three ops back to back across the counter wrap.
        force dut.cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.cnt_q;
        #1;
        check("wrap_preset", retire_cnt, 32'hFFFF_FFFE);
        c_ovr = 1'b0; in_valid = 1'b1; in_rs = 5'd0; in_rt = 5'd0;
        for (int i = 0; i < 3; i++) begin
            in_op = stream_ops[i];
            in_rd = AddrW'(i + 1);
            #1;
            check("st_in_ready", {31'd0, in_ready}, 32'd1);
            tick();
            check("st_alu_op", {29'd0, alu_op}, {29'd0, stream_ops[i]});
            check("st_out_valid", {31'd0, out_valid}, 32'd1);
            check("st_cnt", retire_cnt, stream_cnt[i]);
        end
        in_valid = 1'b0;
        tick();
        check("wrap_cnt", retire_cnt, 32'd1);
        check("wrap_drain", {31'd0, out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
